aes_mixcol_seq: RTL and testbench
=================================

# aes_mixcol_seq

Column-serial MixColumns/AddRoundKey round stage for the AES datapath. Accepts a full 128-bit state plus round key over a valid/ready handshake. Streams the four 32-bit columns through a single column MixColumns unit, one per cycle, XORs in the round key, and returns the reassembled 128-bit state. Sits directly downstream of the SubBytes/ShiftRows stage and feeds the round-state register. It is the only consumer of the column MixColumns unit.

## Interface
- No parameters; widths fixed by AES (128-bit state, 32-bit column).
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input state/key/mode presented
- in_ready  out  1  stage can accept; transfer when in_valid && in_ready
- in_state  in  128  state; column c = bits [127-32c -: 32], row 0 in column MSB byte
- in_key  in  128  round key, same column/byte layout
- in_ed  in  1  0 = encrypt (forward MixColumns), 1 = decrypt (inverse MixColumns)
- in_last  in  1  1 = final round: skip MixColumns, AddRoundKey only
- out_valid  out  1  result held stable until out_ready
- out_ready  in  1  downstream accepts; transfer when out_valid && out_ready
- out_state  out  128  result, same layout as in_state
- busy  out  1  high in RUN

## Operation
- FSM states: IDLE, RUN, DONE. Column counter col[1:0].
- IDLE: in_ready=1. On transfer, capture state, key, ed, last; set col=0; go RUN.
- RUN: in_ready=0. Each cycle processes column col:
  - encrypt: r = MC(s_col) ^ k_col
  - decrypt: r = InvMC(s_col ^ k_col)
  - last=1 (either mode): r = s_col ^ k_col
- RUN writes r into result column col and increments col. After col==3, go DONE.
- DONE: out_valid=1, out_state = result.
  - out_ready=0: hold.
  - out_ready=1 and in_valid=0: go IDLE.
  - out_ready=1 and in_valid=1: in_ready=1 this cycle. Capture the new input, go RUN with col=0, no bubble.
- Inputs are ignored whenever in_ready=0. in_* need not be held after transfer.
- GF(2^8) arithmetic modulo x^8+x^4+x^3+x+1. The column unit's E_D input is driven by the captured ed.

## Timing
- Reset values: in_ready=1 (IDLE), out_valid=0, busy=0, out_state=0, col=0, captured registers 0.
- Latency: transfer at edge T → RUN during cycles T+1..T+4 → out_valid=1 from cycle T+5.
- Throughput: one block per 5 cycles with out_ready held high (DONE overlaps the next accept).
- out_state changes only on RUN column writes. out_state is not required to be stable while out_valid=0.
- rst asserted in any state (including mid-RUN, or DONE with out_valid=1) returns to IDLE next edge with reset values. The partial result is discarded and no out_valid is produced.
- The column datapath is combinational within the RUN cycle: one column unit, one 32-bit XOR, one 32-bit pre-XOR mux. No internal pipeline.

## Structure
- Shared AES package holds: FSM state encoding (IDLE/RUN/DONE), column-slice helper constants (NCOL=4, COLW=32), and E_D encoding constants (ENC=0, DEC=1).
- One sub-module: the existing 32-bit column MixColumns unit AesMixCol, instantiated once. Port mapping: E_D, DIn = column (pre-XORed with key in decrypt), DOut.
- Key column and state column are selected by col via a 4:1 mux. Result is a 128-bit register with column write-enable.

## Test plan
- Encrypt, key=0, last=0, in_state=db135345_f20a225c_01010101_c6c6c6c6 → out_state=8e4da1bc_9fdc589d_01010101_c6c6c6c6 at T+5.
- Decrypt, key=0, in_state=8e4da1bc_9fdc589d_01010101_c6c6c6c6 → out_state=db135345_f20a225c_01010101_c6c6c6c6. Then decrypt with key=K on (MC(X)^K) for X=d4d4d4d5_2d26314c_… → X.
- last=1, in_ed=0 and 1, in_state=00112233_44556677_8899aabb_ccddeeff, key=all-ff → out_state=ffeeddcc_bbaa9988_77665544_33221100 for both modes.
- Backpressure: out_ready low 3 cycles in DONE → out_valid and out_state stable, in_ready=0. Then out_ready=1 with in_valid=1 → same-cycle accept, next out_valid exactly 5 cycles later.
- rst pulsed at second RUN cycle → next cycle IDLE, in_ready=1, out_valid=0, out_state=0. No stale out_valid afterwards.
- Random back-to-back stream (≥1000 blocks, random ed/last/out_ready) checked against a software MixColumns/AddRoundKey model. Block ordering preserved, no drops or duplicates.

Source files
------------

// File: rtl/aes_mixcol_seq_pkg.sv
// Shared constants for the column-serial MixColumns/AddRoundKey stage.
package aes_mixcol_seq_pkg;
  // FSM encoding
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Column slicing of the 128-bit state
  localparam int NCOL = 4;
  localparam int COLW = 32;

  // E_D encoding
  localparam logic ENC = 1'b0;
  localparam logic DEC = 1'b1;

  // Multiply by x in GF(2^8) mod x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
endpackage

// File: rtl/aes_mixcol_seq_mixcol.sv
// Single 32-bit column MixColumns unit, forward (E_D=0) or inverse (E_D=1).
// Row 0 of the column is the MSB byte.
module AesMixCol
  import aes_mixcol_seq_pkg::*;
(
  input  logic        E_D,
  input  logic [31:0] DIn,
  output logic [31:0] DOut
);
  logic [7:0] b  [4];
  logic [7:0] m2 [4];
  logic [7:0] m4 [4];
  logic [7:0] m8 [4];

  // Row bytes and their x, x^2, x^3 multiples; each output row is a rotated
  // dot product with {2,3,1,1} forward or {14,11,13,9} inverse.
  always_comb begin
    DOut = '0;
    for (int r = 0; r < 4; r++) begin
      b[r]  = DIn[31-8*r -: 8];
      m2[r] = xtime(b[r]);
      m4[r] = xtime(m2[r]);
      m8[r] = xtime(m4[r]);
    end
    for (int r = 0; r < 4; r++) begin
      if (E_D == ENC)
        DOut[31-8*r -: 8] = m2[r] ^ (m2[(r+1)%4] ^ b[(r+1)%4]) ^ b[(r+2)%4] ^ b[(r+3)%4];
      else
        DOut[31-8*r -: 8] = (m8[r] ^ m4[r] ^ m2[r])
                          ^ (m8[(r+1)%4] ^ m2[(r+1)%4] ^ b[(r+1)%4])
                          ^ (m8[(r+2)%4] ^ m4[(r+2)%4] ^ b[(r+2)%4])
                          ^ (m8[(r+3)%4] ^ b[(r+3)%4]);
    end
  end
endmodule

// File: rtl/aes_mixcol_seq.sv
// Column-serial MixColumns/AddRoundKey round stage: captures a 128-bit
// state + key, runs four columns through one column unit, returns the state.
module aes_mixcol_seq
  import aes_mixcol_seq_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic [127:0] in_key,
  input  logic         in_ed,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);
  logic [1:0] fsm;
  logic [1:0] col;
  // Index NCOL-1-c holds column c, so column 0 sits in the MSBs
  logic [NCOL-1:0][COLW-1:0] st_q, key_q, res_q;
  logic ed_q, last_q;

  logic [COLW-1:0] s_col, k_col, sk_col, mc_in, mc_out, r_col;
  logic accept;

  assign in_ready  = (fsm == S_IDLE) || (fsm == S_DONE && out_ready);
  assign out_valid = (fsm == S_DONE);
  assign busy      = (fsm == S_RUN);
  assign out_state = res_q;
  assign accept    = in_valid && in_ready;

  // Column datapath: 4:1 select, key pre-XOR for decrypt, post-XOR for encrypt
  always_comb begin
    s_col  = st_q[~col];
    k_col  = key_q[~col];
    sk_col = s_col ^ k_col;
    mc_in  = (ed_q == DEC) ? sk_col : s_col;
    if (last_q)
      r_col = sk_col;
    else if (ed_q == DEC)
      r_col = mc_out;
    else
      r_col = mc_out ^ k_col;
  end

  AesMixCol u_mixcol (
    .E_D  (ed_q),
    .DIn  (mc_in),
    .DOut (mc_out)
  );

  // FSM, input capture and column-wise result writes
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm    <= S_IDLE;
      col    <= '0;
      st_q   <= '0;
      key_q  <= '0;
      res_q  <= '0;
      ed_q   <= 1'b0;
      last_q <= 1'b0;
    end else begin
      if (accept) begin
        st_q   <= in_state;
        key_q  <= in_key;
        ed_q   <= in_ed;
        last_q <= in_last;
        col    <= '0;
      end
      case (fsm)
        S_IDLE: if (accept) fsm <= S_RUN;
        S_RUN: begin
          res_q[~col] <= r_col;
          col         <= col + 2'd1;
          if (col == 2'd3) fsm <= S_DONE;
        end
        S_DONE: if (out_ready) fsm <= accept ? S_RUN : S_IDLE;
        default: fsm <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_mixcol_seq.sv
// Self-checking bench: directed vectors plus a random stream against a
// byte-level GF(2^8) matrix model of MixColumns/AddRoundKey.
module tb_aes_mixcol_seq;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_state = '0;
  logic [127:0] in_key = '0;
  logic         in_ed = 1'b0;
  logic         in_last = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_state;
  logic         busy;

  aes_mixcol_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_state(in_state), .in_key(in_key), .in_ed(in_ed), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [31:0] mixcol(input logic [31:0] c, input bit inv);
    logic [7:0] coef [4];
    logic [7:0] a [4];
    logic [31:0] o = '0;
    if (inv) begin coef[0] = 8'd14; coef[1] = 8'd11; coef[2] = 8'd13; coef[3] = 8'd9; end
    else     begin coef[0] = 8'd2;  coef[1] = 8'd3;  coef[2] = 8'd1;  coef[3] = 8'd1; end
    for (int r = 0; r < 4; r++) a[r] = c[31-8*r -: 8];
    for (int r = 0; r < 4; r++) begin
      logic [7:0] acc = 8'h00;
      for (int j = 0; j < 4; j++) acc = acc ^ gmul(coef[(j-r+4)%4], a[j]);
      o[31-8*r -: 8] = acc;
    end
    return o;
  endfunction

  function automatic logic [127:0] blk(input logic [127:0] s, input logic [127:0] k,
                                       input bit ed, input bit last);
    logic [127:0] o = '0;
    for (int c = 0; c < 4; c++) begin
      logic [31:0] sc = s[127-32*c -: 32];
      logic [31:0] kc = k[127-32*c -: 32];
      if (last)    o[127-32*c -: 32] = sc ^ kc;
      else if (ed) o[127-32*c -: 32] = mixcol(sc ^ kc, 1'b1);
      else         o[127-32*c -: 32] = mixcol(sc, 1'b0) ^ kc;
    end
    return o;
  endfunction

  // ---------------- per-cycle compare process ----------------
  logic [127:0] expq[$];
  bit  have = 0;
  int  age = 0;
  bit  rst_prev = 1;
  bit  prev_hold = 0;
  logic [127:0] prev_out = '0;
  int  n_acc = 0, n_out = 0, n_drop = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_prev) begin
        n_drop += expq.size();
        expq.delete();
        have = 0;
        prev_hold = 0;
        chk("reset_out_state", out_state, 128'h0);
      end
      chk("out_valid", out_valid, have && age >= 4);
      chk("busy", busy, have && age < 4);
      chk("in_ready", in_ready, !have || (age >= 4 && out_ready));
      if (prev_hold) chk("hold_stable", out_state, prev_out);
      prev_hold = out_valid && !out_ready && !rst;
      prev_out  = out_state;
      if (!rst && out_valid && out_ready) begin
        if (expq.size() == 0) chk("unexpected_output", 1, 0);
        else chk("stream_data", out_state, expq.pop_front());
        have = 0;
        n_out++;
      end
      if (!rst && in_valid && in_ready) begin
        expq.push_back(blk(in_state, in_key, in_ed, in_last));
        have = 1;
        age = -1;
        n_acc++;
      end
      if (have) age++;
      rst_prev = rst;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic send(input logic [127:0] s, input logic [127:0] k, input bit e, input bit l);
    in_valid = 1'b1; in_state = s; in_key = k; in_ed = e; in_last = l;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
    end
    chk("send_timeout", 1, 0);
    in_valid = 1'b0;
  endtask

  task automatic get(input logic [127:0] exp, input string name);
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        chk(name, out_state, exp);
        @(posedge clk); #1;
        out_ready = 1'b0;
        return;
      end
    end
    chk({name, "_timeout"}, 1, 0);
    out_ready = 1'b0;
  endtask

  localparam logic [127:0] V_X  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V_Y  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V_L  = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] V_LR = 128'hffeeddcc_bbaa9988_77665544_33221100;
  localparam logic [127:0] V_X2 = 128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6;
  localparam logic [127:0] V_K  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] ONES = {128{1'b1}};

  initial begin
    logic [127:0] s2, k2, y;
    int lat;
    bit e2, l2;

    // Pin the model with hand-checked vectors
    chk("model_enc", blk(V_X, 128'h0, 1'b0, 1'b0), V_Y);
    chk("model_dec", blk(V_Y, 128'h0, 1'b1, 1'b0), V_X);
    chk("model_last_enc", blk(V_L, ONES, 1'b0, 1'b1), V_LR);
    chk("model_last_dec", blk(V_L, ONES, 1'b1, 1'b1), V_LR);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    send(V_X, 128'h0, 1'b0, 1'b0);  get(V_Y, "enc_vector");
    send(V_Y, 128'h0, 1'b1, 1'b0);  get(V_X, "dec_vector");
    y = blk(V_X2, V_K, 1'b0, 1'b0);
    send(y, V_K, 1'b1, 1'b0);       get(V_X2, "dec_keyed");
    send(V_L, ONES, 1'b0, 1'b1);    get(V_LR, "last_enc");
    send(V_L, ONES, 1'b1, 1'b1);    get(V_LR, "last_dec");

    // Backpressure then same-cycle re-accept
    send({$urandom, $urandom, $urandom, $urandom}, V_K, 1'b0, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_out_valid", out_valid, 1'b1);
    end
    @(posedge clk); #1;
    s2 = {$urandom, $urandom, $urandom, $urandom};
    k2 = {$urandom, $urandom, $urandom, $urandom};
    out_ready = 1'b1;
    in_valid = 1'b1; in_state = s2; in_key = k2; in_ed = 1'b1; in_last = 1'b0;
    @(negedge clk);
    chk("b2b_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) break;
      lat++;
    end
    chk("b2b_latency", lat, 4);
    chk("b2b_data", out_state, blk(s2, k2, 1'b1, 1'b0));
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset in the second RUN cycle
    send(V_X, 128'h0, 1'b0, 1'b0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_state", out_state, 128'h0);
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;

    // Random back-to-back stream
    begin
      int base = n_acc;
      int cyc = 0;
      while (n_acc - base < 1000 && cyc < 20000) begin
        e2 = 1'($urandom);
        l2 = ($urandom % 4) == 0;
        in_valid  = ($urandom % 4) != 0;
        in_state  = {$urandom, $urandom, $urandom, $urandom};
        in_key    = {$urandom, $urandom, $urandom, $urandom};
        in_ed     = e2;
        in_last   = l2;
        out_ready = ($urandom % 4) != 0;
        @(posedge clk); #1;
        cyc++;
      end
      chk("stream_progress", (n_acc - base >= 1000), 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && expq.size() != 0; i++) @(posedge clk);
    #1;
    chk("stream_count", n_out, n_acc - n_drop);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
